// File: rtl/traffic_conflict_monitor_if.sv
// Lamp bundle from the NS/EW controller plus the monitor's decoded status.
// The master drives the lamps and the slave (the monitor) drives the status.
interface traffic_conflict_monitor_if #(
  parameter int CNT_W = 5,
  parameter int CYC_W = 16
);
  logic             ns_red;
  logic             ns_yellow;
  logic             ns_green;
  logic             ew_red;
  logic             ew_yellow;
  logic             ew_green;
  logic [1:0]       phase;
  logic             phase_valid;
  logic [CNT_W-1:0] dwell;
  logic [CYC_W-1:0] cycle_count;
  logic             fault;
  logic [2:0]       fault_code;
  logic             flash_red;

  modport master (
    output ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    input  phase, phase_valid, dwell, cycle_count, fault, fault_code, flash_red
  );

  modport slave (
    input  ns_red, ns_yellow, ns_green, ew_red, ew_yellow, ew_green,
    output phase, phase_valid, dwell, cycle_count, fault, fault_code, flash_red
  );
endinterface

// File: rtl/traffic_conflict_monitor.sv
// Lamp-output checker: decodes phase, checks legality/order/dwell each sample; status is
// valid one edge after the sample, first violation latches a sticky code and a flash-red request.
module traffic_conflict_monitor #(
  parameter int GREEN_CYCLES  = 25,
  parameter int YELLOW_CYCLES = 5,
  parameter int CNT_W         = 5,
  parameter int CYC_W         = 16,
  parameter int FLASH_HALF    = 8
) (
  input  logic clk,
  input  logic reset,
  traffic_conflict_monitor_if.slave mon
);

  localparam int FL_W = $clog2(FLASH_HALF + 1);
  localparam logic [CNT_W-1:0] GRN_REQ   = CNT_W'(GREEN_CYCLES);
  localparam logic [CNT_W-1:0] YEL_REQ   = CNT_W'(YELLOW_CYCLES);
  localparam logic [FL_W-1:0]  FLASH_MAX = FL_W'(FLASH_HALF - 1);

  localparam logic [1:0] PH_NS_G = 2'b00;
  localparam logic [1:0] PH_NS_Y = 2'b01;
  localparam logic [1:0] PH_EW_G = 2'b10;
  localparam logic [1:0] PH_EW_Y = 2'b11;

  localparam logic [2:0] C_NONE      = 3'd0;
  localparam logic [2:0] C_CONFLICT  = 3'd1;
  localparam logic [2:0] C_ILLEGAL   = 3'd2;
  localparam logic [2:0] C_SEQUENCE  = 3'd3;
  localparam logic [2:0] C_TOO_LONG  = 3'd4;
  localparam logic [2:0] C_TOO_SHORT = 3'd5;

  typedef enum logic [1:0] {SYNC, TRACK, FAULT} state_t;

  state_t           state_q, state_d;
  logic [1:0]       phase_q, phase_d;
  logic             valid_q, valid_d;
  logic [CNT_W-1:0] dwell_q, dwell_d;
  logic [CYC_W-1:0] cyc_q, cyc_d;
  logic             partial_q, partial_d;
  logic             fault_q, fault_d;
  logic [2:0]       code_q, code_d;
  logic             flash_q, flash_d;
  logic [FL_W-1:0]  fcnt_q, fcnt_d;

  logic [5:0]       pat;
  logic             legal;
  logic [1:0]       pat_ph;
  logic             conflict;
  logic [CNT_W-1:0] req;
  logic [2:0]       viol;

  assign pat = {mon.ns_red, mon.ns_yellow, mon.ns_green,
                mon.ew_red, mon.ew_yellow, mon.ew_green};
  assign conflict = (mon.ns_yellow | mon.ns_green) & (mon.ew_yellow | mon.ew_green);
  assign req = phase_q[0] ? YEL_REQ : GRN_REQ;

  always_comb begin
    legal  = 1'b1;
    pat_ph = PH_NS_G;
    case (pat)
      6'b001_100: pat_ph = PH_NS_G;
      6'b010_100: pat_ph = PH_NS_Y;
      6'b100_001: pat_ph = PH_EW_G;
      6'b100_010: pat_ph = PH_EW_Y;
      default:    legal  = 1'b0;
    endcase
  end

  always_comb begin
    state_d   = state_q;
    phase_d   = phase_q;
    valid_d   = valid_q;
    dwell_d   = dwell_q;
    cyc_d     = cyc_q;
    partial_d = partial_q;
    fault_d   = fault_q;
    code_d    = code_q;
    flash_d   = flash_q;
    fcnt_d    = fcnt_q;
    viol      = C_NONE;

    case (state_q)
      SYNC: begin
        if (!legal) begin
          viol = conflict ? C_CONFLICT : C_ILLEGAL;
        end else begin
          phase_d   = pat_ph;
          dwell_d   = CNT_W'(1);
          valid_d   = 1'b1;
          partial_d = 1'b1;
          state_d   = TRACK;
        end
      end
      TRACK: begin
        if (!legal) begin
          viol = conflict ? C_CONFLICT : C_ILLEGAL;
        end else if (pat_ph == phase_q) begin
          if (dwell_q == req) viol = C_TOO_LONG;
          else                dwell_d = dwell_q + 1'b1;
        end else if (pat_ph == phase_q + 2'd1) begin
          // The phase adopted at sync may have started before we saw it.
          if (dwell_q != req && !partial_q) begin
            viol = C_TOO_SHORT;
          end else begin
            phase_d   = pat_ph;
            dwell_d   = CNT_W'(1);
            partial_d = 1'b0;
            if (phase_q == PH_EW_Y) cyc_d = cyc_q + 1'b1;
          end
        end else begin
          viol = C_SEQUENCE;
        end
      end
      FAULT: begin
        if (fcnt_q == FLASH_MAX) begin
          flash_d = ~flash_q;
          fcnt_d  = '0;
        end else begin
          fcnt_d  = fcnt_q + 1'b1;
        end
      end
      default: state_d = SYNC;
    endcase

    if (viol != C_NONE) begin
      state_d = FAULT;
      fault_d = 1'b1;
      code_d  = viol;
      valid_d = 1'b0;
      flash_d = 1'b1;
      fcnt_d  = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= SYNC;
      phase_q   <= PH_NS_G;
      valid_q   <= 1'b0;
      dwell_q   <= '0;
      cyc_q     <= '0;
      partial_q <= 1'b0;
      fault_q   <= 1'b0;
      code_q    <= C_NONE;
      flash_q   <= 1'b0;
      fcnt_q    <= '0;
    end else begin
      state_q   <= state_d;
      phase_q   <= phase_d;
      valid_q   <= valid_d;
      dwell_q   <= dwell_d;
      cyc_q     <= cyc_d;
      partial_q <= partial_d;
      fault_q   <= fault_d;
      code_q    <= code_d;
      flash_q   <= flash_d;
      fcnt_q    <= fcnt_d;
    end
  end

  assign mon.phase       = phase_q;
  assign mon.phase_valid = valid_q;
  assign mon.dwell       = dwell_q;
  assign mon.cycle_count = cyc_q;
  assign mon.fault       = fault_q;
  assign mon.fault_code  = code_q;
  assign mon.flash_red   = flash_q;

endmodule
